// File: rtl/cpu_ctrl_sequencer_pkg.sv
// cpu_ctrl_sequencer_pkg: opcodes, state encoding and decode helpers for the sequencer
package cpu_ctrl_sequencer_pkg;
  localparam int INSTR_W = 8;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ASL   = 3'b001;
  localparam logic [2:0] OP_XNOR  = 3'b010;
  localparam logic [2:0] OP_DIV2  = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_NEG   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_OPRD,
    S_OPWAIT, S_EXEC, S_WB, S_STORE, S_HALTED
  } state_t;
  // ALU ops whose result goes back to RAM instead of AC
  function automatic logic wb_to_mem(input logic [2:0] op);
    return op == OP_ASL || op == OP_DIV2 || op == OP_NEG;
  endfunction
endpackage

// File: rtl/cpu_ctrl_sequencer.sv
// cpu_ctrl_sequencer: fetch/decode/execute controller feeding an external 8-bit ALU
module cpu_ctrl_sequencer
  import cpu_ctrl_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        alu_ac,
  output logic [7:0]        alu_dr,
  output logic [2:0]        alu_mode,
  output logic              alu_activate,
  input  logic [7:0]        alu_result,
  output logic [7:0]        ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_done,
  output logic              halted
);
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   pc, ar;
  logic [INSTR_W-1:0]  ir;
  logic [7:0]          dr, ac;
  logic                halt_entry;
  logic [2:0]          op;

  assign op       = ir[INSTR_W-1:INSTR_W-3];
  assign alu_mode = op;
  assign alu_ac   = ac;
  assign alu_dr   = dr;
  assign ac_out   = ac;
  assign pc_out   = pc;
  assign halted   = state == S_HALTED;

  // state register; async reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state and bus/ALU strobes, decoded from state and held registers only
  always_comb begin
    nxt          = state;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    alu_activate = 1'b0;
    instr_done   = 1'b0;
    case (state)
      S_IDLE:   nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_addr = pc;
        mem_rd   = 1'b1;
        nxt      = S_FWAIT;
      end
      S_FWAIT:  nxt = S_DECODE;
      S_DECODE: nxt = op == OP_HALT ? S_HALTED : op == OP_STORE ? S_STORE : S_OPRD;
      S_OPRD: begin
        mem_addr = ar;
        mem_rd   = 1'b1;
        nxt      = S_OPWAIT;
      end
      S_OPWAIT: nxt = S_EXEC;
      S_EXEC: begin
        alu_activate = 1'b1;
        nxt          = S_WB;
      end
      S_WB: begin
        mem_wr     = wb_to_mem(op);
        mem_addr   = wb_to_mem(op) ? ar : '0;
        mem_wdata  = wb_to_mem(op) ? alu_result : '0;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_STORE: begin
        mem_addr   = ar;
        mem_wr     = 1'b1;
        mem_wdata  = ac;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_HALTED: begin
        instr_done = halt_entry;
        nxt        = start ? S_FETCH : S_HALTED;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  // architectural registers: PC, IR, AR, DR, AC and the halt-entry marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= START;
      ir         <= '0;
      ar         <= '0;
      dr         <= '0;
      ac         <= '0;
      halt_entry <= 1'b0;
    end else begin
      halt_entry <= state == S_DECODE && op == OP_HALT;
      if ((state == S_IDLE || state == S_HALTED) && start) pc <= START;
      if (state == S_FWAIT) ir <= mem_rdata;
      if (state == S_DECODE) begin
        ar <= ADDR_W'(ir[4:0]);
        pc <= pc + 1'b1;
      end
      if (state == S_OPWAIT) dr <= mem_rdata;
      if (state == S_WB && !wb_to_mem(op)) ac <= alu_result;
    end
  end
endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// tb_cpu_ctrl_sequencer: instruction-level model plus directed programs for the sequencer
module tb_cpu_ctrl_sequencer;
  logic       clk = 0, rst_n = 1, start = 0;
  logic [4:0] mem_addr, pc_out;
  logic       mem_rd, mem_wr, alu_activate, instr_done, halted;
  logic [7:0] mem_wdata, mem_rdata, alu_ac, alu_dr, alu_result, ac_out;
  logic [2:0] alu_mode;

  logic       poke_en = 0;
  logic [4:0] poke_a = 0;
  logic [7:0] poke_d = 0;
  logic [7:0] ram [32];
  logic [7:0] rdata = 0, alu_q = 0;

  int n_chk = 0, n_pass = 0;

  logic [7:0] m_ram [32];
  logic [7:0] m_ac = 0;
  logic [4:0] m_pc = 0;
  logic       m_halted = 0, active = 0;
  int cyc = 0, rd = 0, wr = 0, acts = 0;
  int done_total = 0, act_total = 0, wr_total = 0;
  logic [2:0] e_op;
  logic [4:0] e_a, e_npc;
  logic [7:0] e_d, e_nac, e_wdata;
  int         e_lat;
  logic       e_nw, e_alu;

  cpu_ctrl_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_mode(alu_mode),
    .alu_activate(alu_activate), .alu_result(alu_result),
    .ac_out(ac_out), .pc_out(pc_out), .instr_done(instr_done), .halted(halted)
  );

  always #5 clk = ~clk;

  // ALU behaviour assumed for the attached 8-bit ALU
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    case (op)
      3'b000:  return a + d;
      3'b001:  return {d[6:0], 1'b0};
      3'b010:  return ~(a ^ d);
      3'b011:  return {1'b0, d[7:1]};
      3'b100:  return d;
      3'b110:  return 8'(0 - int'(d));
      default: return 8'h00;
    endcase
  endfunction

  // environment: sync RAM with 1-cycle read latency, ALU result ready the cycle after activate
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) rdata <= ram[mem_addr];
    if (alu_activate) alu_q <= alu_f(alu_mode, alu_ac, alu_dr);
  end
  assign mem_rdata  = rdata;
  assign alu_result = alu_q;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // what the instruction at m_pc must do, from the ISA rules
  task automatic predict();
    logic [7:0] ins;
    ins     = m_ram[m_pc];
    e_op    = ins[7:5];
    e_a     = ins[4:0];
    e_d     = m_ram[e_a];
    e_npc   = m_pc + 5'd1;
    e_alu   = e_op != 3'b101 && e_op != 3'b111;
    e_lat   = e_alu ? 7 : 4;
    e_nw    = e_op inside {3'b001, 3'b011, 3'b110, 3'b101};
    e_wdata = e_op == 3'b101 ? m_ac : alu_f(e_op, m_ac, e_d);
    e_nac   = (e_alu && !e_nw) ? alu_f(e_op, m_ac, e_d) : m_ac;
  endtask

  // compare process: checks every cycle against the instruction-level model
  initial forever begin
    @(negedge clk);
    if (poke_en) m_ram[poke_a] = poke_d;
    if (!rst_n) begin
      active = 0; m_ac = 0; m_pc = 0; m_halted = 0;
    end else begin
      if (active) cyc++;
      chk("ac", ac_out, m_ac);
      chk("alu_ac", alu_ac, m_ac);
      chk("pc", pc_out, (active && cyc >= 4) ? e_npc : m_pc);
      chk("rd_wr_excl", mem_rd & mem_wr, 0);
      chk("halted", halted, active ? (cyc == 4 && e_op == 3'b111) : m_halted);
      if (active) begin
        if (mem_rd) begin
          rd++;
          chk("rd_addr", mem_addr, rd == 1 ? m_pc : e_a);
          chk("rd_cyc", cyc, rd == 1 ? 1 : 4);
        end
        if (mem_wr) begin
          wr++; wr_total++;
          chk("wr_addr", mem_addr, e_a);
          chk("wr_data", mem_wdata, e_wdata);
          chk("wr_cyc", cyc, e_lat);
        end
        if (alu_activate) begin
          acts++; act_total++;
          chk("act_cyc", cyc, 6);
          chk("alu_dr", alu_dr, e_d);
        end
        if (cyc >= 3) chk("mode", alu_mode, e_op);
        if (instr_done || cyc > e_lat) begin
          done_total++;
          chk("len", cyc, e_lat);
          chk("reads", rd, e_alu ? 2 : 1);
          chk("writes", wr, e_nw);
          chk("acts", acts, e_alu);
          m_ac = e_nac;
          m_pc = e_npc;
          if (e_nw) m_ram[e_a] = e_wdata;
          if (e_op == 3'b111) begin
            m_halted = 1; active = 0;
          end else begin
            predict(); cyc = 0; rd = 0; wr = 0; acts = 0;
          end
        end
      end else begin
        chk("idle_strobes", {mem_rd, mem_wr, alu_activate, instr_done}, 0);
        if (start) begin
          m_pc = 0; m_halted = 0; predict();
          cyc = 0; rd = 0; wr = 0; acts = 0; active = 1;
        end
      end
    end
  end

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #2 poke_en = 1; poke_a = a; poke_d = d;
    @(posedge clk); #2 poke_en = 0;
  endtask

  task automatic go();
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
  endtask

  task automatic wait_halt(input int n);
    int k = 0;
    while (!halted && k < n) begin @(negedge clk); #1; k++; end
    chk("halt_wait", halted, 1);
  endtask

  task automatic wait_act(input int n);
    int k = 0;
    while (!alu_activate && k < n) begin @(negedge clk); #1; k++; end
    chk("act_wait", alu_activate, 1);
  endtask

  task automatic wait_rd(input int n);
    int k = 0;
    while (!mem_rd && k < n) begin @(negedge clk); #1; k++; end
    chk("rd_wait", mem_rd, 1);
  endtask

  task automatic wait_done(input int target, input int n);
    int k = 0;
    while (done_total < target && k < n) begin @(negedge clk); #1; k++; end
    chk("done_wait", done_total >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, w0, d0;
    #1 rst_n = 0;
    for (int i = 0; i < 32; i++) poke(5'(i), 8'h00);
    @(negedge clk); #1;
    chk("rst_pc", pc_out, 0);
    chk("rst_ac", ac_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", {mem_rd, mem_wr, alu_activate, instr_done}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mode", alu_mode, 0);
    chk("rst_dr", alu_dr, 0);
    @(posedge clk); #2 rst_n = 1;
    repeat (3) @(posedge clk);

    // LOAD 5 then HALT
    poke(0, 8'h85); poke(5, 8'h3C); poke(1, 8'hE0);
    a0 = act_total;
    go(); wait_halt(40);
    chk("t1_ac", ac_out, 8'h3C);
    chk("t1_pc", pc_out, 2);
    chk("t1_acts", act_total - a0, 1);

    // LOAD 5, ADD 6, STORE 7, HALT
    poke(1, 8'h06); poke(6, 8'h0A); poke(2, 8'hA7); poke(3, 8'hE0);
    a0 = act_total; w0 = wr_total;
    go(); wait_halt(60);
    chk("t2_ac", ac_out, 8'h46);
    chk("t2_pc", pc_out, 4);
    chk("t2_ram7", ram[7], 8'h46);
    chk("t2_writes", wr_total - w0, 1);
    chk("t2_acts", act_total - a0, 2);

    // NEG 8, DIV2 9, ASL 10, XNOR 11, HALT with AC=0x46 carried over
    poke(0, 8'hC8); poke(1, 8'h69); poke(2, 8'h2A); poke(3, 8'h4B); poke(4, 8'hE0);
    poke(8, 8'h01); poke(9, 8'h81); poke(10, 8'h55); poke(11, 8'hF0);
    w0 = wr_total;
    go(); wait_halt(80);
    chk("t3_ram8", ram[8], 8'hFF);
    chk("t3_ram9", ram[9], 8'h40);
    chk("t3_ram10", ram[10], 8'hAA);
    chk("t3_ac", ac_out, 8'h49);
    chk("t3_pc", pc_out, 5);
    chk("t3_writes", wr_total - w0, 3);

    // every word is LOAD of itself: PC wraps 31 -> 0
    for (int i = 0; i < 32; i++) poke(5'(i), 8'h80 | 8'(i));
    d0 = done_total;
    go(); wait_done(d0 + 32, 300);
    chk("t4_wrap_pc", pc_out, 0);
    wait_rd(5);
    chk("t4_wrap_fetch", mem_addr, 0);
    chk("t4_ac31", ac_out, 8'h9F);
    wait_done(d0 + 35, 40);
    go();
    wait_act(10);
    chk("t4_start_ignored", pc_out, 4);
    rst_n = 0;
    #1 chk("t4_async_act", alu_activate, 0);
    repeat (2) @(negedge clk); #1;
    chk("t4_rst_ac", ac_out, 0);
    chk("t4_rst_pc", pc_out, 0);
    chk("t4_rst_halted", halted, 0);
    @(posedge clk); #2 rst_n = 1;
    repeat (3) @(posedge clk);
    chk("t4_idle", {mem_rd, mem_wr}, 0);

    // reset during the RAM writeback of NEG 8
    poke(0, 8'hC8); poke(8, 8'h01);
    go(); wait_act(10);
    @(posedge clk); #2;
    chk("t5_wb_wr", mem_wr, 1);
    rst_n = 0;
    #1 chk("t5_async_wr", mem_wr, 0);
    repeat (2) @(negedge clk); #1;
    chk("t5_ram8", ram[8], 8'h01);
    chk("t5_ac", ac_out, 0);
    chk("t5_pc", pc_out, 0);
    @(posedge clk); #2 rst_n = 1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
